// File: rtl/instr_mem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit
// instruction-memory writes. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module instr_mem_loader #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned MAX_WORDS     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [31:0]              wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef LOADER_CHECKSUM_EN
    , S_CHK = 3'd7
`endif
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_LAST = S_CHK;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  localparam state_e S_LAST = S_DONE;
`endif

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_e                   state_r;
  state_e                   state_s;
  logic                     accept_s;
  logic                     start_ok_s;
  logic [7:0]               byte_s;
  logic [15:0]              len_s;
  logic [15:0]              len_r;
  logic [15:0]              word_count_r;
  logic [1:0]               byte_idx_r;
  logic [23:0]              lane_r;
  logic [ADDRESS_WIDTH-1:0] wr_addr_r;
  logic [31:0]              wr_data_r;
  logic                     byte_ready_r;
  logic                     wr_en_r;
  logic                     cpu_hold_r;
  logic                     done_r;
  logic                     error_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               csum_r;
`endif

  assign byte_s     = byte_in[7:0];
  assign accept_s   = byte_valid && byte_ready_r;
  assign len_s      = {byte_s, len_r[7:0]};
  assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_s = S_LEN0;
        else       state_s = state_r;
      end
      S_LEN0: begin
        if (accept_s) state_s = S_LEN1;
        else          state_s = state_r;
      end
      S_LEN1: begin
        if (!accept_s)            state_s = state_r;
        else if (len_s == 16'd0)  state_s = S_LAST;
        else if (len_s > MAX_N)   state_s = S_ERR;
        else                      state_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (byte_idx_r == 2'd3)) state_s = S_WRITE;
        else                                   state_s = state_r;
      end
      S_WRITE: begin
        if ((word_count_r + 16'd1) == len_r) state_s = S_LAST;
        else                                  state_s = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!accept_s)              state_s = state_r;
        else if (byte_s == csum_r)  state_s = S_DONE;
        else                        state_s = S_ERR;
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      len_r        <= 16'd0;
      word_count_r <= 16'd0;
      byte_idx_r   <= 2'd0;
      lane_r       <= 24'd0;
      wr_addr_r    <= ADDRESS_WIDTH'(BASE_ADDR);
      wr_data_r    <= 32'd0;
      byte_ready_r <= 1'b0;
      wr_en_r      <= 1'b0;
      cpu_hold_r   <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      state_r      <= state_s;
      byte_ready_r <= (state_s == S_LEN0) || (state_s == S_LEN1) || (state_s == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                      || (state_s == S_CHK)
`endif
                      ;
      wr_en_r      <= (state_s == S_WRITE);
      cpu_hold_r   <= (state_s != S_IDLE) && (state_s != S_DONE);
      done_r       <= (state_s == S_DONE);
      error_r      <= (state_s == S_ERR);
      if (start_ok_s) begin
        len_r        <= 16'd0;
        word_count_r <= 16'd0;
        byte_idx_r   <= 2'd0;
        lane_r       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
        csum_r       <= 8'd0;
`endif
      end else begin
        case (state_r)
          S_LEN0: if (accept_s) len_r[7:0]  <= byte_s;
          S_LEN1: if (accept_s) len_r[15:8] <= byte_s;
          S_DATA: begin
            if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
              csum_r <= csum_step(csum_r, byte_s);
`endif
              // Lanes shift downward so the first byte ends up as the LSB.
              if (byte_idx_r == 2'd3) begin
                wr_data_r  <= {byte_s, lane_r};
                wr_addr_r  <= ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'({word_count_r, 2'b00});
                byte_idx_r <= 2'd0;
              end else begin
                lane_r     <= {byte_s, lane_r[23:8]};
                byte_idx_r <= byte_idx_r + 2'd1;
              end
            end
          end
          S_WRITE: word_count_r <= word_count_r + 16'd1;
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = word_count_r;

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Boot-time program loader: the write side of the instruction memory that the fetch/decode path reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one write per word into instruction memory.
- Holds the CPU stalled while loading; reports done or error.

Parameters:
- ADDRESS_WIDTH, 32, width of wr_addr (byte address).
- DATA_WIDTH, 8, width of the incoming stream byte.
- BASE_ADDR, 32'h0, byte address of the first word written.
- MAX_WORDS, 1024, largest legal word count; must be ≤ 65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_in  input  DATA_WIDTH  stream byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction-memory write strobe.
- wr_addr  output  ADDRESS_WIDTH  byte address of the word being written.
- wr_data  output  32  assembled instruction word.
- cpu_hold  output  1  stall/reset request to the CPU.
- done  output  1  load completed successfully.
- error  output  1  load aborted.
- word_count  output  16  words written so far in the current load.

Behaviour:
- Handshake: a byte transfers on a rising edge where byte_valid && byte_ready. byte_valid may be held across cycles; no byte is lost or duplicated.
- Stream format: length low byte, length high byte (N = word count), then 4·N data bytes, each word LSB first.
- States and transitions:
  - IDLE: byte_ready=0. start → LEN0.
  - LEN0: byte_ready=1. Accept → latch N[7:0], go LEN1.
  - LEN1: byte_ready=1. Accept → latch N[15:8], then:
    - N==0 → DONE.
    - N > MAX_WORDS → ERR.
    - otherwise → DATA, byte index 0.
  - DATA: byte_ready=1. Each accept shifts the byte into lane[byte index]. The 4th byte → WRITE.
  - WRITE (exactly 1 cycle): wr_en=1, byte_ready=0.
    - wr_addr = BASE_ADDR + 4·word_count.
    - wr_data = {b3,b2,b1,b0}.
    - word_count increments at the end of the cycle.
    - Then: word_count+1 == N → DONE (or CHK with the optional feature), else → DATA.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start → LEN0.
  - ERR: error=1, cpu_hold=1, byte_ready=0. start → LEN0.
- On start from DONE or ERR: done, error, word_count and byte index clear in the same edge.
- start received in LEN0, LEN1, DATA, WRITE or CHK is ignored.
- Bytes presented in IDLE, DONE or ERR are not accepted, because byte_ready=0.
- cpu_hold = 1 in LEN0, LEN1, DATA, WRITE, CHK and ERR; 0 in IDLE and DONE.
- Throughput: at most 4 bytes per 5 cycles per word; wr_en latency is 1 cycle after the 4th byte accept.
- wr_addr and wr_data hold their last values outside WRITE. wr_addr wraps modulo 2^ADDRESS_WIDTH.
- Reset, asynchronous at any time including mid-word:
  - State → IDLE.
  - byte_ready, wr_en, cpu_hold, done, error = 0.
  - wr_addr = BASE_ADDR; wr_data, word_count, N, byte index = 0.
  - A partially assembled word is discarded and never written.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro:
  - After the last WRITE, go to state CHK (byte_ready=1, cpu_hold=1).
  - Accept one checksum byte equal to the XOR of all 4·N data bytes. Length bytes are excluded; for N==0 the expected value is 8'h00 and LEN1 goes to CHK.
  - Match → DONE. Mismatch → ERR.
- Without the macro: no CHK state, no checksum byte; the last WRITE goes straight to DONE.

Test Plan:
- Reset then idle: all outputs at reset values; byte_valid=1 with byte_in=8'hAA for 10 cycles → byte_ready stays 0, no wr_en.
- start, stream 02 00 13 05 10 00 93 05 20 00 (back-to-back valid):
  - wr_en pulse 1: wr_addr=BASE_ADDR, wr_data=32'h00100513.
  - wr_en pulse 2: wr_addr=BASE_ADDR+4, wr_data=32'h00200593.
  - Then done=1, cpu_hold=0, word_count=2.
  - With LOADER_CHECKSUM_EN, append byte 8'hB0 → same result.
- Same stream with byte_valid toggling 1/0 randomly → identical writes and data; no duplicated or lost bytes.
- Length 00 00 → DONE with no wr_en (checksum build: byte 00 required). Length 01 04 (N=1025 > MAX_WORDS) → error=1, cpu_hold=1, no wr_en.
- Assert rst after 6 data bytes of a 2-word load → immediate IDLE, no write of the partial word; a new start plus full stream succeeds.
- Checksum build: correct stream with checksum 8'hB1 → error=1 after 2 writes; start then correct reload → done=1.
